// File: rtl/fifo_wr_packer_if.sv
// Write-side packer bus: narrow beat stream in, FIFO write port and status out.
interface fifo_wr_packer_if #(
    parameter int unsigned IN_WIDTH        = 8,
    parameter int unsigned FIFO_DATA_WIDTH = 32
);
    logic                       in_valid;
    logic [IN_WIDTH-1:0]        in_data;
    logic                       in_last;
    logic                       in_ready;
    logic                       wrreq;
    logic [FIFO_DATA_WIDTH-1:0] data;
    logic                       wrfull;
    logic                       prog_full;
    logic [15:0]                word_cnt;
    logic [15:0]                frame_cnt;

    // Packer side: consumes the beat stream, drives the FIFO write port.
    modport master (
        input  in_valid, in_data, in_last, wrfull, prog_full,
        output in_ready, wrreq, data, word_cnt, frame_cnt
    );

    // Environment side: beat source plus FIFO flags.
    modport slave (
        output in_valid, in_data, in_last, wrfull, prog_full,
        input  in_ready, wrreq, data, word_cnt, frame_cnt
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Packs a narrow beat stream into big-endian FIFO words, padding short final
// words and holding a completed word while the FIFO reports full.
module fifo_wr_packer #(
    parameter int unsigned          IN_WIDTH        = 8,
    parameter int unsigned          FIFO_DATA_WIDTH = 32,
    parameter logic [IN_WIDTH-1:0]  PAD_VALUE       = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    fifo_wr_packer_if.master  bus
);
    localparam int unsigned LANES = FIFO_DATA_WIDTH / IN_WIDTH;
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CW    = 16;

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                     state;
    logic [LW-1:0]              lane_cnt;
    logic [FIFO_DATA_WIDTH-1:0] acc;
    logic [FIFO_DATA_WIDTH-1:0] data_q;
    logic                       wrreq_q;
    logic                       pend_last;
    logic [CW-1:0]              word_cnt_q;
    logic [CW-1:0]              frame_cnt_q;

    logic                       in_ready_c;
    logic                       accept_c;
    logic                       complete_c;
    logic [FIFO_DATA_WIDTH-1:0] word_c;

    // Ready is forced low while reset is held so nothing is accepted in reset.
    always_comb begin
        in_ready_c = sys_rst_n && (state == FILL) && !bus.prog_full;
        accept_c   = bus.in_valid && in_ready_c;
        complete_c = accept_c && (bus.in_last || (lane_cnt == LW'(LANES - 1)));
    end

    // Current word with the incoming beat merged in; lanes past it get PAD.
    always_comb begin
        word_c = acc;
        for (int i = 0; i < int'(LANES); i++) begin
            if (i == int'(lane_cnt)) begin
                word_c[FIFO_DATA_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = bus.in_data;
            end else if (i > int'(lane_cnt)) begin
                word_c[FIFO_DATA_WIDTH-1-i*IN_WIDTH -: IN_WIDTH] = PAD_VALUE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= FILL;
            lane_cnt    <= '0;
            acc         <= '0;
            data_q      <= '0;
            wrreq_q     <= 1'b0;
            pend_last   <= 1'b0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            wrreq_q <= 1'b0;
            case (state)
                FILL: begin
                    if (accept_c) begin
                        if (complete_c) begin
                            data_q   <= word_c;
                            lane_cnt <= '0;
                            if (!bus.wrfull) begin
                                wrreq_q    <= 1'b1;
                                word_cnt_q <= word_cnt_q + CW'(1);
                                if (bus.in_last) begin
                                    frame_cnt_q <= frame_cnt_q + CW'(1);
                                end
                            end else begin
                                state     <= PEND;
                                pend_last <= bus.in_last;
                            end
                        end else begin
                            acc      <= word_c;
                            lane_cnt <= lane_cnt + LW'(1);
                        end
                    end
                end
                PEND: begin
                    // A finished word drains on wrfull alone; prog_full only gates input.
                    if (!bus.wrfull) begin
                        wrreq_q    <= 1'b1;
                        state      <= FILL;
                        word_cnt_q <= word_cnt_q + CW'(1);
                        if (pend_last) begin
                            frame_cnt_q <= frame_cnt_q + CW'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.wrreq     = wrreq_q;
    assign bus.data      = data_q;
    assign bus.word_cnt  = word_cnt_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Randomized and directed bench for fifo_wr_packer against a queue-based
// reference model of the packing, padding and full-flag rules.
module tb_fifo_wr_packer;
    localparam int unsigned IW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = DW / IW;

    typedef struct {
        logic [DW-1:0] word;
        bit            last;
    } exp_t;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    fifo_wr_packer_if #(.IN_WIDTH(IW), .FIFO_DATA_WIDTH(DW)) bus ();

    fifo_wr_packer #(
        .IN_WIDTH(IW), .FIFO_DATA_WIDTH(DW), .PAD_VALUE(8'h00)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [IW-1:0] cur_q[$];
    exp_t          exp_q[$];
    bit            m_pend = 1'b0;
    bit            m_wr   = 1'b0;
    logic [15:0]   m_words  = '0;
    logic [15:0]   m_frames = '0;
    logic [DW-1:0] last_wr  = '0;

    function automatic logic [DW-1:0] build_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w = w << IW;
            if (i < cur_q.size()) w[IW-1:0] = cur_q[i];
        end
        return w;
    endfunction

    // Observe outputs mid-cycle, then predict the effect of the coming edge.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
            chk("rst_wrreq", 64'(bus.wrreq), 64'd0);
            chk("rst_data", 64'(bus.data), 64'd0);
            chk("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
            chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
            cur_q.delete();
            exp_q.delete();
            m_pend = 1'b0;
            m_wr = 1'b0;
            m_words = '0;
            m_frames = '0;
        end else begin
            bit   ready_m;
            bit   new_wr;
            exp_t e;
            ready_m = !bus.prog_full && !m_pend;
            chk("in_ready", 64'(bus.in_ready), 64'(ready_m));
            chk("wrreq", 64'(bus.wrreq), 64'(m_wr));
            if (bus.wrreq) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 64'(bus.data), 64'(e.word));
                    m_words++;
                    if (e.last) m_frames++;
                end
                last_wr = bus.data;
            end else begin
                chk("word_cnt", 64'(bus.word_cnt), 64'(m_words));
                chk("frame_cnt", 64'(bus.frame_cnt), 64'(m_frames));
            end
            new_wr = 1'b0;
            if (m_pend) begin
                if (!bus.wrfull) begin
                    new_wr = 1'b1;
                    m_pend = 1'b0;
                end
            end else if (bus.in_valid && ready_m) begin
                cur_q.push_back(bus.in_data);
                if (bus.in_last || cur_q.size() == LANES) begin
                    e.word = build_word();
                    e.last = bus.in_last;
                    exp_q.push_back(e);
                    cur_q.delete();
                    if (!bus.wrfull) new_wr = 1'b1;
                    else m_pend = 1'b1;
                end
            end
            m_wr = new_wr;
        end
    end

    task automatic send(input logic [IW-1:0] b, input bit last);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        @(negedge sys_clk);
        while (!bus.in_ready && t < 1000) begin
            @(negedge sys_clk);
            t++;
        end
        if (t >= 1000) chk("send_timeout", 64'(t), 64'd0);
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.wrfull    = 1'b0;
        bus.prog_full = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Basic packing
        for (int i = 1; i <= 8; i++) send(IW'(i * 8'h11), 1'b0);
        idle(3);
        chk("basic_word_cnt", 64'(bus.word_cnt), 64'd2);
        chk("basic_last", 64'(last_wr), 64'h55667788);

        // Short frames with padding
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        idle(3);
        chk("pad2_data", 64'(last_wr), 64'hAABB0000);
        chk("pad2_frames", 64'(bus.frame_cnt), 64'd1);
        send(8'hCC, 1'b1);
        idle(3);
        chk("pad1_data", 64'(last_wr), 64'hCC000000);
        chk("pad1_frames", 64'(bus.frame_cnt), 64'd2);

        // Full stall holds the word in PEND
        bus.wrfull = 1'b1;
        for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
        idle(3);
        chk("pend_ready", 64'(bus.in_ready), 64'd0);
        chk("pend_wrreq", 64'(bus.wrreq), 64'd0);
        chk("pend_data", 64'(bus.data), 64'h01020304);
        bus.wrfull = 1'b0;
        idle(3);
        chk("pend_release", 64'(last_wr), 64'h01020304);
        chk("pend_word_cnt", 64'(bus.word_cnt), 64'd5);

        // prog_full throttles mid-word
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        bus.prog_full = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h30;
        repeat (5) @(posedge sys_clk);
        #1;
        chk("throttle_ready", 64'(bus.in_ready), 64'd0);
        bus.prog_full = 1'b0;
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        idle(3);
        chk("throttle_data", 64'(last_wr), 64'h10203040);

        // Reset mid-frame discards the partial word
        send(8'hDE, 1'b0);
        send(8'hAD, 1'b0);
        do_reset();
        for (int i = 1; i <= 4; i++) send(IW'(i), 1'b0);
        idle(3);
        chk("post_rst_data", 64'(last_wr), 64'h01020304);
        chk("post_rst_cnt", 64'(bus.word_cnt), 64'd1);

        // Random traffic with flag noise
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_data   = IW'($urandom);
            bus.in_last   = ($urandom % 6) == 0;
            bus.wrfull    = ($urandom % 5) == 0;
            bus.prog_full = ($urandom % 7) == 0;
            @(posedge sys_clk);
            #1;
        end
        bus.wrfull    = 1'b0;
        bus.prog_full = 1'b0;
        idle(10);

        // Counter wrap: 65536 single-beat frames
        do_reset();
        for (int i = 0; i < 65536; i++) send(IW'($urandom), 1'b1);
        idle(3);
        chk("wrap_word0", 64'(bus.word_cnt), 64'd0);
        chk("wrap_frame0", 64'(bus.frame_cnt), 64'd0);
        send(8'h5A, 1'b1);
        idle(3);
        chk("wrap_word1", 64'(bus.word_cnt), 64'd1);
        chk("wrap_data", 64'(last_wr), 64'h5A000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_packer.md
# fifo_wr_packer

Write-side packer that sits directly upstream of the asynchronous show-ahead FIFO in the write clock domain. It accepts a narrow byte stream with valid/ready handshake and frame delimiter, packs bytes into FIFO-width words, and drives the FIFO write port (`wrreq`/`data`). It honours the FIFO's `wrfull` and `prog_full` flags so that no word is ever written into a full FIFO and no input byte is lost.

## Interface

Parameters:
- `IN_WIDTH`, 8: input beat width in bits.
- `FIFO_DATA_WIDTH`, 32: FIFO word width. Must be an integer multiple of `IN_WIDTH`, with LANES = FIFO_DATA_WIDTH/IN_WIDTH ≥ 2.
- `PAD_VALUE`, 0: `IN_WIDTH`-bit fill value for unused lanes of a short final word.

Ports:
- Reset is `sys_rst_n`, asynchronous, active-low. The clock is `sys_clk`.
- `sys_clk` in 1: write-domain clock, the same clock as FIFO `wrclk`.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: input beat valid.
- `in_data` in IN_WIDTH: input beat.
- `in_last` in 1: beat is the last of its frame.
- `in_ready` out 1: packer accepts a beat this cycle.
- `wrreq` out 1: FIFO write strobe.
- `data` out FIFO_DATA_WIDTH: FIFO write data.
- `wrfull` in 1: FIFO full flag.
- `prog_full` in 1: FIFO programmable-full flag.
- `word_cnt` out 16: words written since reset, wraps.
- `frame_cnt` out 16: frames completed since reset, wraps.

## Operation

- A beat is accepted on a rising `sys_clk` edge when `in_valid & in_ready` holds.
- Lane order is big-endian. The first beat of a word goes to bits [FIFO_DATA_WIDTH-1 : FIFO_DATA_WIDTH-IN_WIDTH]; subsequent beats fill the next lower lanes.
- The lane counter is `$clog2(LANES)` bits wide, counts 0..LANES-1, and returns to 0 after a word completes.
- A word completes when the accepted beat lands in lane LANES-1, or when the accepted beat has `in_last`=1.
  - On an `in_last` completion, lanes not yet written are set to `PAD_VALUE`.
  - A frame never shares a word with the next frame.
- The state machine has two states:
  - FILL: `in_ready` = !`prog_full`.
    - On a completing beat with `wrfull`=0 sampled on that edge: `data` is loaded with the word, `wrreq` goes to 1 for the next cycle, and the state stays FILL. This means back-to-back accumulation with no bubble.
    - On a completing beat with `wrfull`=1: the word is loaded into `data`, `wrreq` stays 0, and the state moves to PEND.
  - PEND: `in_ready`=0. On each edge, if `wrfull`=0 then `wrreq`←1 for one cycle and the state moves to FILL; otherwise the state stays in PEND.
- `wrreq` is registered and is high for exactly one cycle per completed word. `data` stays stable from load until the next word is loaded.
- `word_cnt` increments on every cycle where `wrreq`=1.
- `frame_cnt` increments on the same cycle as the `wrreq` of a word that was completed by `in_last`.
- Both counters wrap from 0xFFFF to 0x0000.
- Byte order within a word and word order are preserved end to end. Nothing is dropped or duplicated.

## Timing

- Reset values: `in_ready`=0 while in reset, `wrreq`=0, `data`=0, `word_cnt`=0, `frame_cnt`=0, state=FILL, lane counter=0. Any partially packed word is discarded.
- After reset release, `in_ready` follows !`prog_full` combinationally from the first cycle.
- Latency: if the completing beat is accepted on edge N, `wrreq`/`data` are valid during cycle N to N+1 and the FIFO samples them on edge N+1.
- Throughput: with `prog_full`=0, one beat per cycle and one word per LANES cycles.
- `prog_full` throttles input only. A word already completed is still written once `wrfull`=0; `prog_full` does not stall PEND.
- Simultaneous events:
  - `in_last` on lane LANES-1 produces one completion with no padding.
  - `in_last` on lane 0 produces a word of PAD in all lower lanes.
- Reset asserted mid-frame or in PEND forces the reset values immediately, asynchronously. No `wrreq` glitch is permitted.

## Test plan

- Basic packing: after reset, send beats 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88 with `wrfull`=`prog_full`=0 → two `wrreq` pulses with `data` 0x11223344 then 0x55667788, `word_cnt`=2, no idle cycles on `in_ready`.
- Short frame padding: send 0xAA,0xBB with `in_last` on 0xBB, PAD_VALUE=0 → `data`=0xAABB0000, `frame_cnt`=1. Then send a single beat 0xCC with `in_last` → `data`=0xCC000000, `frame_cnt`=2.
- Full stall: hold `wrfull`=1 and complete the word 0x01020304 → `wrreq` stays 0, `in_ready`=0 (PEND), `data`=0x01020304. Release `wrfull` → exactly one `wrreq` pulse one cycle later with the same data.
- prog_full throttle: assert `prog_full` in the middle of a word → `in_ready`=0 and no beats accepted. Deassert it → packing resumes and the resulting word contains all bytes in order.
- Reset mid-operation: accept 0xDE,0xAD, then pulse `sys_rst_n` low → outputs return to reset values. Next send 0x01..0x04 → `data`=0x01020304 with no residue of 0xDEAD.
- Counter wrap: preload by streaming 65536 words → `word_cnt` returns to 0x0000 and the next word makes it 0x0001.
